// File: rtl/vector_pkg.sv
// Shared constants and types for the vector result writer.
// A vector is split into BEATS memory words, each stored with its own address.
package vector_pkg;

  localparam int VEC_W  = 128;
  localparam int MEM_W  = 32;
  localparam int BEATS  = VEC_W / MEM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/vector_result_writer_if.sv
// Bundles the vector input handshake and the data-memory store port.
// The master side offers vectors and models memory; the slave side is the writer.
interface vector_result_writer_if
  import vector_pkg::*;
#(
  parameter int N  = VEC_W,
  parameter int W  = MEM_W,
  parameter int AW = 32
) ();

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [AW-1:0] in_addr;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          busy;
  logic          done;

  modport master (
    output in_valid, in_data, in_addr, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_addr, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

endinterface

// File: rtl/vector_result_writer.sv
// Stores one N-bit ALU result vector as N/W consecutive W-bit memory beats.
// All store-port outputs come from flops, so in_* never reaches mem_* combinationally.
module vector_result_writer
  import vector_pkg::*;
#(
  parameter int N  = VEC_W,
  parameter int W  = MEM_W,
  parameter int AW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_result_writer_if.slave bus
);

  localparam int            NB         = N / W;
  localparam int            CW         = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BEAT  = CW'(NB - 1);
  localparam logic [AW-1:0] BEAT_BYTES = AW'(W / 8);

  wr_state_e     state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] beat_nx;
  logic [N-1:0]  data_q, data_d;
  logic [AW-1:0] base_q, base_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0]  mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and next-output computation; outputs are precomputed one cycle ahead
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    data_d      = data_q;
    base_d      = base_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    beat_nx     = beat_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d     = WRITE;
          data_d      = bus.in_data;
          base_d      = bus.in_addr;
          beat_d      = '0;
          mem_we_d    = 1'b1;
          busy_d      = 1'b1;
          mem_addr_d  = bus.in_addr;
          mem_wdata_d = bus.in_data[W-1:0];
        end else begin
          mem_we_d    = 1'b0;
          busy_d      = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d     = IDLE;
            beat_d      = '0;
            mem_we_d    = 1'b0;
            busy_d      = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            done_d      = 1'b1;
          end else begin
            beat_d      = beat_nx;
            // Address arithmetic is deliberately modulo 2^AW
            mem_addr_d  = base_q + (AW'(beat_nx) * BEAT_BYTES);
            mem_wdata_d = data_q[beat_nx*W +: W];
          end
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d     = IDLE;
        beat_d      = '0;
        mem_we_d    = 1'b0;
        busy_d      = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      data_q      <= '0;
      base_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      data_q      <= data_d;
      base_q      <= base_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/vector_result_writer.md
Name: vector_result_writer

Overview:
- Memory-side counterpart of the vectorial ALU datapath. Accepts one 128-bit ALU result vector (16 packed 8-bit pixel lanes) together with a base address.
- Serialises the vector into W-bit data-memory store beats with incrementing addresses, and stalls on memory back-pressure.
- Sits between the ALU result register and the data memory write port of the alpha-composition ASIP.

Parameters:
- N, 128, vector width in bits; must be a multiple of W.
- W, 32, memory data word width in bits; must be a multiple of 8.
- AW, 32, byte-address width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  vector + address offered
- in_ready  output  1  writer can accept a vector
- in_data  input  N  vector to store; lane 0 in bits [7:0]
- in_addr  input  AW  byte base address of the store
- mem_we  output  1  store beat valid
- mem_ready  input  1  memory accepts the current beat
- mem_addr  output  AW  byte address of the current beat
- mem_wdata  output  W  data of the current beat
- busy  output  1  store in progress
- done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- BEATS = N/W (4 at defaults). Beat k carries data_q[k*W +: W] at address base_q + k*(W/8), computed modulo 2^AW (wraps at the top of the address space). There is no alignment check; the low base bits pass through unchanged.
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; beat counter = 0; data_q = 0; base_q = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, done = 0.
  - in_ready is forced to 0 while rst is high.
- Reset mid-store aborts the store immediately. No further beats are issued, and done does not pulse.
- States:
  - IDLE:
    - in_ready = 1, mem_we = 0, busy = 0.
    - mem_addr and mem_wdata are driven to 0.
    - On in_valid & in_ready: latch in_data → data_q and in_addr → base_q, set beat = 0, go to WRITE.
  - WRITE:
    - in_ready = 0, busy = 1, mem_we = 1.
    - mem_addr and mem_wdata are driven from beat, base_q and data_q.
    - On mem_ready = 1 with beat < BEATS-1: beat increments.
    - On mem_ready = 1 with beat = BEATS-1: go to IDLE, and done = 1 in the following cycle.
    - On mem_ready = 0: all outputs hold stable, and no beat is skipped or repeated.
- Latency: the first beat is presented the cycle after acceptance. With mem_ready tied high a vector takes BEATS cycles in WRITE, and done rises on the IDLE cycle that follows.
- Throughput:
  - The done cycle is also an IDLE cycle with in_ready = 1, so the next vector can be accepted there.
  - Steady-state throughput is one vector per BEATS+1 cycles.
- Changes on in_data or in_addr while in WRITE are ignored.
- If in_valid is held without acceptance, nothing is latched.
- Outputs are driven directly from state and registers; there is no combinational path from in_* to mem_*.

Decomposition:
- Shared package vector_pkg:
  - VEC_W = 128 and MEM_W = 32 constants.
  - BEATS = VEC_W/MEM_W constant.
  - Typedef for the writer state enum {IDLE, WRITE}.
  - Beat counter width constant, $clog2(BEATS).
- Single module; no sub-module is warranted. Beat slice selection is an indexed part-select, not a separate mux instance.

Test Plan:
- Basic store, mem_ready=1: in_data=128'h0F0E0D0C_0B0A0908_07060504_03020100 at in_addr=32'h100 → beats (100, 03020100), (104, 07060504), (108, 0B0A0908), (10C, 0F0E0D0C) on 4 consecutive cycles, then done=1 for one cycle.
- Back-pressure: same vector with mem_ready low for 3 cycles during beat 1 → mem_addr held at 0x104 with data 07060504 for all stalled cycles, 4 writes total, done after beat 3 accepted.
- Address wrap: in_addr=32'hFFFFFFF8 → beats at FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Back-to-back: in_valid held high with two vectors A, B → B accepted on A's done cycle; no beat of A is lost or overwritten; 10 cycles from A accept to B done.
- Reset mid-store: rst asserted during beat 2 → next cycle mem_we=0, mem_addr=0, mem_wdata=0, busy=0, no done pulse; in_ready=1 in the first cycle after rst deasserts.
- Input isolation: in_data and in_addr toggled randomly during WRITE → stored beats match the values latched at acceptance.
